// File: rtl/psram_seq.sv
// psram_seq - Octal-DDR PSRAM transaction sequencer.
//
// Turns one burst request from the bus front end into the pin-level CE#/SCK/DQ/DQS
// sequence: CMD (2 bytes), ADDR (4 bytes), latency, then write or read data, then a
// CE# recovery gap. SCK runs at clk_i/2 and one DQ byte moves per clk_i cycle.
// Every pin output and every status output is registered.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      burst request handshake (ready only in IDLE)
//   req_wr_i, req_addr_i,        write/read select, byte address, SCK data cycles-1
//   req_len_i
//   wdata_valid_i/wdata_ready_o, write byte stream; ready marks the fetch cycle
//   wdata_i
//   rdata_valid_o, rdata_o       read byte stream, no backpressure
//   done_o, err_o                end-of-burst pulse, read-timeout flag
//   psram_*                      pad-side out/en/in signals for CE#, SCK, DQ, DQS/DM
module psram_seq #(
  parameter int LAT_CYC  = 5,
  parameter int LEN_W    = 8,
  parameter int TCPH_CYC = 4,
  parameter int RD_TMO   = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_wr_i,
  input  logic [31:0]      req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [7:0]       wdata_i,
  output logic             rdata_valid_o,
  output logic [7:0]       rdata_o,
  output logic             done_o,
  output logic             err_o,
  output logic             psram_ce_o,
  output logic             psram_sck_o,
  output logic [7:0]       psram_io_out_o,
  output logic [7:0]       psram_io_en_o,
  input  logic [7:0]       psram_io_in_i,
  output logic             psram_dqs_out_o,
  output logic             psram_dqs_en_o,
  input  logic             psram_dqs_in_i
);

  localparam int CNT_MAX  = (2*LAT_CYC > TCPH_CYC) ? ((2*LAT_CYC > 4) ? 2*LAT_CYC : 4)
                                                   : ((TCPH_CYC > 4) ? TCPH_CYC : 4);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int TMO_W    = $clog2(RD_TMO + 1);
  localparam int LAT_LAST = 2*LAT_CYC - 1;
  localparam logic ONE_CEHI = (TCPH_CYC == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LAT, S_WDATA, S_RDATA, S_CEHI
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [LEN_W:0]   bcnt_r;      // one bit wider than len so a full-length burst fits
  logic [TMO_W-1:0] tmo_r;
  logic             wr_r;
  logic [31:0]      addr_r;
  logic [LEN_W-1:0] len_r;
  logic             wreq_r;      // this cycle fetches the byte driven next cycle
  logic             dqs_d_r;
  logic             err_pend_r;
  logic             ready_r, ce_r, sck_r, dqs_en_r;
  logic [7:0]       io_out_r, io_en_r, rdata_r;
  logic             rvalid_r, done_r, err_r;

  logic [LEN_W:0]   last_s;
  logic             wstall_s;
  logic             dqs_edge_s;

  // Index of the final byte: 2*(len+1)-1.
  assign last_s     = {len_r, 1'b1};
  // Only even-slot bytes may be held back by the front end.
  assign wstall_s   = wreq_r & ~bcnt_r[0] & ~wdata_valid_i;
  assign dqs_edge_s = psram_dqs_in_i ^ dqs_d_r;

  // Address byte i of the burst; the device needs an even byte address.
  function automatic logic [7:0] addr_byte(input logic [31:0] a, input logic [1:0] i);
    case (i)
      2'd0:    addr_byte = a[31:24];
      2'd1:    addr_byte = a[23:16];
      2'd2:    addr_byte = a[15:8];
      2'd3:    addr_byte = a[7:0] & 8'hFE;
      default: addr_byte = 8'h00;
    endcase
  endfunction

  // Sequencer FSM; every output register is loaded with its value for the next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      bcnt_r     <= '0;
      tmo_r      <= '0;
      wr_r       <= 1'b0;
      addr_r     <= 32'h0;
      len_r      <= '0;
      wreq_r     <= 1'b0;
      dqs_d_r    <= psram_dqs_in_i;
      err_pend_r <= 1'b0;
      ready_r    <= 1'b1;
      ce_r       <= 1'b1;
      sck_r      <= 1'b0;
      dqs_en_r   <= 1'b0;
      io_out_r   <= 8'h00;
      io_en_r    <= 8'h00;
      rdata_r    <= 8'h00;
      rvalid_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      dqs_d_r  <= psram_dqs_in_i;
      rvalid_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (req_valid_i) begin
            wr_r       <= req_wr_i;
            addr_r     <= req_addr_i;
            len_r      <= req_len_i;
            state_r    <= S_CMD;
            cnt_r      <= '0;
            bcnt_r     <= '0;
            err_pend_r <= 1'b0;
            ready_r    <= 1'b0;
            ce_r       <= 1'b0;
            sck_r      <= 1'b0;
            io_out_r   <= req_wr_i ? 8'h80 : 8'h00;
            io_en_r    <= 8'hFF;
          end
        end
        S_CMD: begin
          sck_r <= ~sck_r;
          if (cnt_r == '0) begin
            cnt_r <= cnt_r + 1'b1;
          end else begin
            state_r  <= S_ADDR;
            cnt_r    <= '0;
            io_out_r <= addr_byte(addr_r, 2'd0);
          end
        end
        S_ADDR: begin
          sck_r <= ~sck_r;
          if (cnt_r != CNT_W'(3)) begin
            cnt_r    <= cnt_r + 1'b1;
            io_out_r <= addr_byte(addr_r, cnt_r[1:0] + 2'd1);
          end else begin
            state_r  <= S_LAT;
            cnt_r    <= '0;
            io_out_r <= 8'h00;
            io_en_r  <= 8'h00;
          end
        end
        S_LAT: begin
          if (cnt_r != CNT_W'(LAT_LAST)) begin
            cnt_r  <= cnt_r + 1'b1;
            sck_r  <= ~sck_r;
            // The first write byte is fetched during the last latency cycle.
            wreq_r <= wr_r && (cnt_r == CNT_W'(LAT_LAST - 1));
          end else if (wr_r) begin
            state_r  <= S_WDATA;
            io_en_r  <= 8'hFF;
            dqs_en_r <= 1'b1;
          end else begin
            state_r <= S_RDATA;
            sck_r   <= ~sck_r;
            tmo_r   <= '0;
          end
        end
        S_WDATA: begin
          if (!wreq_r) begin
            state_r  <= S_CEHI;
            cnt_r    <= '0;
            ce_r     <= 1'b1;
            sck_r    <= 1'b0;
            io_out_r <= 8'h00;
            io_en_r  <= 8'h00;
            dqs_en_r <= 1'b0;
            done_r   <= ONE_CEHI;
          end
        end
        S_RDATA: begin
          if (dqs_edge_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= psram_io_in_i;
            tmo_r    <= '0;
            bcnt_r   <= bcnt_r + 1'b1;
            if (bcnt_r == last_s) begin
              state_r <= S_CEHI;
              cnt_r   <= '0;
              ce_r    <= 1'b1;
              sck_r   <= 1'b0;
              done_r  <= ONE_CEHI;
            end else begin
              sck_r <= ~sck_r;
            end
          end else if (tmo_r == TMO_W'(RD_TMO - 1)) begin
            state_r    <= S_CEHI;
            cnt_r      <= '0;
            ce_r       <= 1'b1;
            sck_r      <= 1'b0;
            err_pend_r <= 1'b1;
            done_r     <= ONE_CEHI;
            err_r      <= ONE_CEHI;
          end else begin
            tmo_r <= tmo_r + 1'b1;
            sck_r <= ~sck_r;
          end
        end
        S_CEHI: begin
          if (cnt_r == CNT_W'(TCPH_CYC - 1)) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
            if (cnt_r == CNT_W'(TCPH_CYC - 2)) begin
              done_r <= 1'b1;
              err_r  <= err_pend_r;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          ready_r <= 1'b1;
          ce_r    <= 1'b1;
          sck_r   <= 1'b0;
          io_en_r <= 8'h00;
        end
      endcase
      // Write byte fetch: odd-slot bytes are taken unconditionally.
      if (wreq_r) begin
        if (wstall_s) begin
          sck_r <= 1'b0;
        end else begin
          io_out_r <= wdata_i;
          sck_r    <= bcnt_r[0];
          bcnt_r   <= bcnt_r + 1'b1;
          wreq_r   <= (bcnt_r != last_s);
        end
      end
    end
  end

  assign req_ready_o     = ready_r;
  assign wdata_ready_o   = wreq_r;
  assign rdata_valid_o   = rvalid_r;
  assign rdata_o         = rdata_r;
  assign done_o          = done_r;
  assign err_o           = err_r;
  assign psram_ce_o      = ce_r;
  assign psram_sck_o     = sck_r;
  assign psram_io_out_o  = io_out_r;
  assign psram_io_en_o   = io_en_r;
  assign psram_dqs_out_o = 1'b0;
  assign psram_dqs_en_o  = dqs_en_r;

endmodule
